gpio_port: RTL and testbench

//  Parametrised memory-mapped GPIO port; successor to the fixed 32-bit GPIO register.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_port_sync.sv | 36 +++
 rtl/gpio_port.sv | 148 ++++++++++++++
 tb/tb_gpio_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register indices and width limit shared by the GPIO port blocks.
package gpio_pkg;

  // Largest supported pin count; the bus data path is at most this wide.
  localparam int GPIO_MAX_WIDTH = 32;

  // Word register indices on the peripheral bus.
  localparam logic [2:0] GPIO_DATA_OUT = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_DATA_IN  = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_RISE_EN  = 3'd4;
  localparam logic [2:0] GPIO_FALL_EN  = 3'd5;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd6;
  localparam logic [2:0] GPIO_OUT_TGL  = 3'd7;

endpackage

// File: rtl/gpio_port_sync.sv
// gpio_sync: WIDTH-bit, SYNC_STAGES-deep flop chain that brings the
// asynchronous pad inputs into the clk domain. Every stage resets to 0.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  // Each stage samples its predecessor; stage 0 samples the pads.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_d[gi] = async_in;
    end else begin : g_rest
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  // Shift the whole chain one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with per-pin direction, toggle writes,
// synchronised inputs and sticky edge-detect interrupts.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  // Edge events stay suppressed until the synchroniser and prev-sample
  // hold real pad values, so pins already high at reset raise nothing.
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [WIDTH-1:0]   dir_q, dir_d;
  logic [WIDTH-1:0]   irq_en_q, irq_en_d;
  logic [WIDTH-1:0]   rise_en_q, rise_en_d;
  logic [WIDTH-1:0]   fall_en_q, fall_en_d;
  logic [WIDTH-1:0]   irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [PRIME_W-1:0] prime_q, prime_d;

  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   edge_evt;
  logic [WIDTH-1:0]   rd_mux;
  logic               primed;
  logic               wr_en;
  logic               rd_en;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (Rst),
    .async_in (pin_in),
    .sync_out (data_in)
  );

  assign wr_en  = sel & we;
  assign rd_en  = sel & ~we;
  assign primed = (prime_q == PRIME_W'(PRIME_MAX));

  // Edge detection on every pin, including driven outputs (loopback).
  always_comb begin
    edge_evt = '0;
    prev_d   = data_in;
    prime_d  = primed ? prime_q : prime_q + 1'b1;
    if (primed) begin
      edge_evt = (data_in & ~prev_q & rise_en_q) | (~data_in & prev_q & fall_en_q);
    end
  end

  // Register file writes; a new event beats a simultaneous W1C clear.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_stat_d = irq_stat_q;
    if (wr_en) begin
      case (addr)
        GPIO_DATA_OUT: data_out_d = wdata;
        GPIO_DIR:      dir_d      = wdata;
        GPIO_IRQ_EN:   irq_en_d   = wdata;
        GPIO_RISE_EN:  rise_en_d  = wdata;
        GPIO_FALL_EN:  fall_en_d  = wdata;
        GPIO_IRQ_STAT: irq_stat_d = irq_stat_q & ~wdata;
        GPIO_OUT_TGL:  data_out_d = data_out_q ^ wdata;
        default:       ;
      endcase
    end
    irq_stat_d = irq_stat_d | edge_evt;
  end

  // Read mux; the toggle register is write-only and reads as zero.
  always_comb begin
    rd_mux = '0;
    case (addr)
      GPIO_DATA_OUT: rd_mux = data_out_q;
      GPIO_DIR:      rd_mux = dir_q;
      GPIO_DATA_IN:  rd_mux = data_in;
      GPIO_IRQ_EN:   rd_mux = irq_en_q;
      GPIO_RISE_EN:  rd_mux = rise_en_q;
      GPIO_FALL_EN:  rd_mux = fall_en_q;
      GPIO_IRQ_STAT: rd_mux = irq_stat_q;
      default:       rd_mux = '0;
    endcase
  end

  // Registered read response; rdata holds until the next read.
  always_comb begin
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_mux : rdata_q;
  end

  // State update for all registers, prime counter and read response.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      data_out_q <= RST_OUT;
      dir_q      <= '0;
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      prime_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      prime_q    <= prime_d;
    end
  end

  assign pin_out = data_out_q;
  assign pin_oe  = dir_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign irq     = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed test of gpio_port. Reads push their expected
// value into a scoreboard queue; a monitor pops on every rvalid pulse.
module tb_gpio_port;

  logic        clk = 1'b0;
  logic        Rst;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] pin_in;
  logic [31:0] pin_out;
  logic [31:0] pin_oe;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  gpio_port #(
    .WIDTH       (32),
    .SYNC_STAGES (2),
    .RST_OUT     (32'h0)
  ) dut (
    .clk     (clk),
    .Rst     (Rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s act=%h exp=%h", name, act, exp);
    end else begin
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (Rst && rvalid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rvalid act=%h exp=none", rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk(e.name, rdata, e.exp);
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; addr = a;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'h0;
    pin_in = 32'hFFFF_FFFF;

    // 1: reset state with all pads high, then no spurious rise after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pin_out", pin_out, 32'h0);
    chk("rst_pin_oe", pin_oe, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    Rst = 1'b1;
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    idle(4);
    bus_read("prime_irq_stat", 3'd6, 32'h0);
    chk("prime_irq", {31'b0, irq}, 32'h0);
    bus_read("data_in_high", 3'd2, 32'hFFFF_FFFF);

    // 2: direction and data out, visible on pads right after the write edge.
    bus_write(3'd1, 32'h0000_FFFF);
    chk("pin_oe_write", pin_oe, 32'h0000_FFFF);
    bus_write(3'd0, 32'h1234_ABCD);
    chk("pin_out_write", pin_out, 32'h1234_ABCD);
    bus_read("read_data_out", 3'd0, 32'h1234_ABCD);
    bus_read("read_dir", 3'd1, 32'h0000_FFFF);

    // 3: toggle mask and write-only read-back.
    bus_write(3'd7, 32'h0000_000F);
    chk("pin_out_toggle", pin_out, 32'h1234_ABC2);
    bus_read("read_after_toggle", 3'd0, 32'h1234_ABC2);
    bus_read("read_tgl_zero", 3'd7, 32'h0);
    bus_write(3'd2, 32'h5555_5555);
    bus_read("data_in_ro", 3'd2, 32'hFFFF_FFFF);

    // 4: rise on pin 3 with exact latency; a fall raises nothing.
    bus_write(3'd4, 32'h0000_0008);
    bus_write(3'd3, 32'h0000_0008);
    pin_in = 32'h0;
    idle(4);
    bus_read("stat_before_rise", 3'd6, 32'h0);
    @(posedge clk); #1;
    pin_in[3] = 1'b1;
    idle(2);
    chk("irq_at_data_in_change", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_after_rise", {31'b0, irq}, 32'h1);
    bus_read("stat_rise3", 3'd6, 32'h0000_0008);
    bus_read("data_in_pin3", 3'd2, 32'h0000_0008);
    bus_write(3'd6, 32'h0000_0008);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);
    pin_in[3] = 1'b0;
    idle(5);
    bus_read("stat_no_fall_evt", 3'd6, 32'h0);

    // 5: W1C lands on the same edge as a new rise -> bit stays set.
    @(posedge clk); #1;
    pin_in[3] = 1'b1;
    idle(2);
    sel = 1'b1; we = 1'b1; addr = 3'd6; wdata = 32'h0000_0008;
    idle(1);
    sel = 1'b0; we = 1'b0;
    bus_read("stat_set_wins", 3'd6, 32'h0000_0008);
    chk("irq_set_wins", {31'b0, irq}, 32'h1);
    bus_write(3'd6, 32'h0000_0008);
    bus_read("stat_w1c_alone", 3'd6, 32'h0);
    chk("irq_w1c_alone", {31'b0, irq}, 32'h0);

    // 6: fall on pin 0 with IRQ masked, then unmask.
    bus_write(3'd5, 32'h0000_0001);
    bus_write(3'd3, 32'h0);
    pin_in[0] = 1'b1;
    idle(5);
    bus_read("stat_no_rise_pin0", 3'd6, 32'h0);
    pin_in[0] = 1'b0;
    idle(5);
    bus_read("stat_fall0", 3'd6, 32'h0000_0001);
    chk("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(3'd3, 32'h0000_0001);
    chk("irq_unmasked", {31'b0, irq}, 32'h1);

    // Reset asserted while a read response is on the bus: response is lost.
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; addr = 3'd0;
    @(posedge clk); #1;
    sel = 1'b0;
    chk("rvalid_before_rst", {31'b0, rvalid}, 32'h1);
    Rst = 1'b0;
    #1;
    chk("rvalid_async_rst", {31'b0, rvalid}, 32'h0);
    chk("rdata_async_rst", rdata, 32'h0);
    chk("pin_out_async_rst", pin_out, 32'h0);
    chk("pin_oe_async_rst", pin_oe, 32'h0);
    chk("irq_async_rst", {31'b0, irq}, 32'h0);
    idle(2);
    Rst = 1'b1;
    bus_read("post_rst_dir", 3'd1, 32'h0);
    bus_read("post_rst_irq_en", 3'd3, 32'h0);
    bus_read("post_rst_fall_en", 3'd5, 32'h0);
    bus_read("post_rst_stat", 3'd6, 32'h0);

    idle(3);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
